// File: rtl/win_scanner.sv
// Sequential N x N win scanner: latches a board on start, tests one anchor per clock
// for K-runs in four directions. Define WIN_SCANNER_EARLY_EXIT_EN to stop at the first winning anchor.
module win_scanner #(
  parameter int N = 5,
  parameter int K = 3,
  localparam int PW = $clog2(N*N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2*N*N-1:0]  board,
  output logic              busy,
  output logic              done,
  output logic              playerwin,
  output logic              player2win,
  output logic              draw,
  output logic [PW-1:0]     win_pos,
  output logic [1:0]        win_dir
);

  localparam int RW = $clog2(N);
  localparam logic [PW-1:0] LAST = PW'(N*N-1);
`ifdef WIN_SCANNER_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t              state_q, state_d;
  logic                load, finish;
  logic                issue_q, issue_d;
  logic [2*N*N-1:0]    board_q;
  logic [PW-1:0]       idx_q;
  logic [RW-1:0]       r_q, c_q;

  logic [3:0]          win1_p0, win2_p0;
  logic [1:0]          anchor_cell;
  logic                empty_p0;

  logic [3:0]          win1_p1, win2_p1;
  logic                empty_p1, last_p1, vld_p1;
  logic [PW-1:0]       idx_p1;
  logic [1:0]          first_dir;

  logic                p1_acc_q, p1_acc_d, p2_acc_q, p2_acc_d;
  logic                empty_acc_q, empty_acc_d, found_q, found_d;
  logic [PW-1:0]       pos_acc_q, pos_acc_d;
  logic [1:0]          dir_acc_q, dir_acc_d;

  logic                done_q, pw_q, p2w_q, draw_q;
  logic [PW-1:0]       pos_q;
  logic [1:0]          dir_q;

  // Off-board coordinates read as empty so partial runs never match a player code.
  function automatic logic [1:0] cell_at(input logic [2*N*N-1:0] b, input int rr, input int cc);
    logic [1:0] v;
    v = 2'd0;
    for (int j = 0; j < N*N; j++)
      if (rr >= 0 && rr < N && cc >= 0 && cc < N && rr*N + cc == j) v = b[2*j +: 2];
    return v;
  endfunction

  function automatic logic run_at(input logic [2*N*N-1:0] b, input int rr, input int cc,
                                  input int d, input logic [1:0] code);
    int   dr, dc;
    logic hit;
    dr  = (d == 0) ? 0 : 1;
    dc  = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
    hit = (rr + dr*(K-1) < N) && (cc + dc*(K-1) < N) && (cc + dc*(K-1) >= 0);
    for (int k = 0; k < K; k++)
      if (cell_at(b, rr + dr*k, cc + dc*k) != code) hit = 1'b0;
    return hit;
  endfunction

  // Stage p0: evaluate the current anchor against the latched board
  always_comb begin
    win1_p0 = '0;
    win2_p0 = '0;
    for (int d = 0; d < 4; d++) begin
      win1_p0[d] = run_at(board_q, int'(r_q), int'(c_q), d, 2'd3);
      win2_p0[d] = run_at(board_q, int'(r_q), int'(c_q), d, 2'd2);
    end
    anchor_cell = cell_at(board_q, int'(r_q), int'(c_q));
    empty_p0    = (anchor_cell < 2'd2);
  end

  // Stage p1: fold the registered anchor result into the accumulators
  always_comb begin
    first_dir = 2'd0;
    for (int d = 3; d >= 0; d--)
      if (win1_p1[d] | win2_p1[d]) first_dir = 2'(d);
    p1_acc_d    = p1_acc_q;
    p2_acc_d    = p2_acc_q;
    empty_acc_d = empty_acc_q;
    found_d     = found_q;
    pos_acc_d   = pos_acc_q;
    dir_acc_d   = dir_acc_q;
    if (vld_p1) begin
      p1_acc_d    = p1_acc_q | (|win1_p1);
      p2_acc_d    = p2_acc_q | (|win2_p1);
      empty_acc_d = empty_acc_q | empty_p1;
      if (!found_q && (|(win1_p1 | win2_p1))) begin
        found_d   = 1'b1;
        pos_acc_d = idx_p1;
        dir_acc_d = first_dir;
      end
    end
    finish = vld_p1 && (last_p1 || (EARLY && (|(win1_p1 | win2_p1))));
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE, DONE: if (start) begin
        state_d = SCAN;
        load    = 1'b1;
      end
      SCAN:    if (finish) state_d = DONE;
      default: state_d = IDLE;
    endcase
    issue_d = issue_q;
    if (load) issue_d = 1'b1;
    else if (issue_q && idx_q == LAST) issue_d = 1'b0;
    if (state_d != SCAN) issue_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      issue_q <= 1'b0;
      vld_p1  <= 1'b0;
      done_q  <= 1'b0;
      pw_q    <= 1'b0;
      p2w_q   <= 1'b0;
      draw_q  <= 1'b0;
      pos_q   <= '0;
      dir_q   <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      vld_p1  <= issue_q && (state_d == SCAN);
      done_q  <= finish;
      if (finish) begin
        pw_q   <= p1_acc_d;
        p2w_q  <= p2_acc_d;
        draw_q <= !p1_acc_d && !p2_acc_d && !empty_acc_d;
        pos_q  <= pos_acc_d;
        dir_q  <= dir_acc_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    win1_p1  <= win1_p0;
    win2_p1  <= win2_p0;
    empty_p1 <= empty_p0;
    idx_p1   <= idx_q;
    last_p1  <= (idx_q == LAST);
    if (load) begin
      board_q     <= board;
      idx_q       <= '0;
      r_q         <= '0;
      c_q         <= '0;
      p1_acc_q    <= 1'b0;
      p2_acc_q    <= 1'b0;
      empty_acc_q <= 1'b0;
      found_q     <= 1'b0;
      pos_acc_q   <= '0;
      dir_acc_q   <= '0;
    end else begin
      p1_acc_q    <= p1_acc_d;
      p2_acc_q    <= p2_acc_d;
      empty_acc_q <= empty_acc_d;
      found_q     <= found_d;
      pos_acc_q   <= pos_acc_d;
      dir_acc_q   <= dir_acc_d;
      if (issue_q) begin
        idx_q <= idx_q + 1'b1;
        if (c_q == RW'(N-1)) begin
          c_q <= '0;
          r_q <= r_q + 1'b1;
        end else begin
          c_q <= c_q + 1'b1;
        end
      end
    end
  end

  assign busy       = (state_q == SCAN);
  assign done       = done_q;
  assign playerwin  = pw_q;
  assign player2win = p2w_q;
  assign draw       = draw_q;
  assign win_pos    = pos_q;
  assign win_dir    = dir_q;

endmodule

// File: doc/win_scanner.md
# win_scanner

Parametrised, sequential successor to the team's combinational win checker. It latches an N×N board of 2-bit cells on a start pulse, then scans one anchor cell per clock. At each anchor it tests all four line directions for a run of K identical player cells, and reports the result with a start/busy/done handshake. It sits between the move-entry logic and the game controller, so boards larger than 5×5 can be checked without a wide combinational cone.

## Interface
- N, default 5: board dimension; legal range 2..8.
- K, default 3: run length needed to win; legal range 2..N.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a scan. Sampled only when busy=0.
- board  input  2*N*N  flattened board. Cell index i = r*N+c occupies bits [2i+1:2i]. Encoding: 2'd3 = player 1, 2'd2 = player 2, 2'd0 or 2'd1 = empty.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when results become valid.
- playerwin  output  1  player 1 has at least one K-run.
- player2win  output  1  player 2 has at least one K-run.
- draw  output  1  no winner and no empty cell.
- win_pos  output  $clog2(N*N)  anchor index of the first winning run found.
- win_dir  output  2  direction of that run: 0 = right, 1 = down, 2 = down-right, 3 = down-left.

## Operation
- **FSM states:** IDLE, SCAN, DONE.
  - IDLE or DONE to SCAN: on start with busy=0. The board is copied into an internal register, the anchor index is cleared to 0, and the internal accumulators are cleared.
  - SCAN: evaluates anchor idx each cycle, then increments idx. After anchor N*N-1, moves to DONE.
  - DONE: holds the results. done is high only in the first cycle after entering DONE.
- **Per anchor (r,c), for each direction d in order 0..3:**
  - A run is tested only if it fits on the board: right needs c+K-1<N; down needs r+K-1<N; down-right needs both; down-left needs c-K+1>=0 and r+K-1<N.
  - A run is a win for player p if all K cells equal p's code.
- **Accumulation:**
  - p1/p2 win flags are ORed across all anchors.
  - win_pos/win_dir capture only the first win found. Scan order is ascending anchor, then ascending direction.
  - An empty-cell flag is ORed from the cell at each anchor.
- **Outputs:**
  - Updated only on the SCAN to DONE transition.
  - Held stable until the next accepted start. They are not cleared when a new scan begins.
  - draw = !p1win & !p2win & !any_empty.
  - If both players win (illegal board), both flags are set. win_pos reports whichever run came first in scan order.
  - If there is no win, win_pos=0 and win_dir=0.
- **Edge cases:**
  - Changes on board during SCAN are ignored, because the scan uses the latched copy.
  - start while busy=1 is ignored and not queued.

## Timing
- **Reset values:** state=IDLE, busy=0, done=0, playerwin=0, player2win=0, draw=0, win_pos=0, win_dir=0.
- **Start and busy:** start is sampled at edge t. busy goes high from t+1. Anchor i is evaluated in the cycle after edge t+1+i.
- **Full-scan latency:** done is high for the cycle following edge t+1+N*N, i.e. N*N+1 cycles after the start edge (26 for N=5). busy drops in the same cycle done rises.
- **Back-to-back scans:** start may be asserted in the done cycle and is accepted there. The next scan begins without an idle gap.
- **Reset mid-scan:** reset during SCAN aborts the scan. State returns to IDLE and all outputs return to their reset values on the next edge.

## Configuration
- **WIN_SCANNER_EARLY_EXIT_EN defined:** SCAN moves to DONE immediately after the first anchor that produces any win. done then arrives i+2 cycles after the start edge, where i is the winning anchor.
  - Only the winning player(s) found at that anchor are flagged.
  - draw is forced to 0 on early exit.
  - draw is computed only on a full scan that finds no win.
- **Macro undefined:** the scan always covers all N*N anchors and has fixed latency.

## Test plan
- **Column win (N=5, K=3, full scan):** cells 4, 9, 14 = 2'd3, all others 0; start → done 26 cycles later; playerwin=1, player2win=0, draw=0, win_pos=4, win_dir=1.
- **Anti-diagonal win for player 2:** cells 4, 8, 12 = 2'd2 → player2win=1, win_pos=4, win_dir=3.
  - With WIN_SCANNER_EARLY_EXIT_EN defined, done arrives 6 cycles after start.
- **Draw:** full 5×5 board of alternating 2'd3/2'd2 with no 3-run → draw=1, both win flags 0, win_pos=0.
- **Both players win:** row 0 cells 0..2 = 2'd3 and row 4 cells 20..22 = 2'd2 → both flags set, win_pos=0, win_dir=0.
- **Reset and handshake:**
  - Assert reset at cycle 10 of a scan → all outputs 0 and busy=0 next cycle.
  - A start pulsed while busy is ignored.
  - Board changes mid-scan do not alter the result.
- **Parameter sweep:** N=8, K=5 with a horizontal run at cells 3..7 → playerwin=1, win_pos=3, win_dir=0, done 65 cycles after start.
